// File: rtl/rcv_frame_ctrl.sv
// Receive-path frame sequencer: parses length-prefixed frames, forwards payload
// through a one-entry output register, checks the additive checksum and counts good frames.
module rcv_frame_ctrl #(
    parameter int MAX_LEN = 16,
    parameter int TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       out_last,
    input  logic       out_ready,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [1:0] err_code,
    output logic [7:0] frame_cnt
);

    typedef enum logic [1:0] {IDLE, PAYLOAD, CHECK} state_t;

    localparam logic [7:0] LEN_MAX = 8'(MAX_LEN);
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t     state_q;
    logic [7:0] sum_q, cnt_q, idle_q;
    logic       out_valid_q, out_last_q, frame_ok_q, frame_err_q;
    logic [7:0] out_data_q, frame_cnt_q;
    logic [1:0] err_code_q;

    logic       accept, len_ok, timeout_hit;
    logic [7:0] sum_d;

    always_comb begin
        in_ready    = (state_q == PAYLOAD) ? (!out_valid_q || out_ready) : 1'b1;
        accept      = in_valid && in_ready;
        len_ok      = (in_data != 8'd0) && (in_data <= LEN_MAX);
        sum_d       = sum_q + in_data;
        // Only true idle cycles count; a backpressured byte (in_valid=1) never times out.
        timeout_hit = (state_q != IDLE) && !in_valid && (idle_q == TO_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sum_q       <= 8'd0;
            cnt_q       <= 8'd0;
            idle_q      <= 8'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'd0;
            out_last_q  <= 1'b0;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            err_code_q  <= 2'b00;
            frame_cnt_q <= 8'd0;
        end else begin
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            // Drain first; a payload load below overrides this in the same cycle.
            if (out_valid_q && out_ready)
                out_valid_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    idle_q <= 8'd0;
                    if (accept) begin
                        if (len_ok) begin
                            sum_q   <= in_data;
                            cnt_q   <= in_data;
                            state_q <= PAYLOAD;
                        end else begin
                            frame_err_q <= 1'b1;
                            err_code_q  <= 2'b01;
                        end
                    end
                end
                PAYLOAD: begin
                    if (accept) begin
                        idle_q      <= 8'd0;
                        sum_q       <= sum_d;
                        cnt_q       <= cnt_q - 8'd1;
                        out_valid_q <= 1'b1;
                        out_data_q  <= in_data;
                        out_last_q  <= (cnt_q == 8'd1);
                        if (cnt_q == 8'd1)
                            state_q <= CHECK;
                    end else if (timeout_hit) begin
                        idle_q      <= 8'd0;
                        frame_err_q <= 1'b1;
                        err_code_q  <= 2'b11;
                        state_q     <= IDLE;
                    end else if (!in_valid) begin
                        idle_q <= idle_q + 8'd1;
                    end
                end
                CHECK: begin
                    if (accept) begin
                        idle_q  <= 8'd0;
                        state_q <= IDLE;
                        if (in_data == sum_q) begin
                            frame_ok_q  <= 1'b1;
                            frame_cnt_q <= frame_cnt_q + 8'd1;
                        end else begin
                            frame_err_q <= 1'b1;
                            err_code_q  <= 2'b10;
                        end
                    end else if (timeout_hit) begin
                        idle_q      <= 8'd0;
                        frame_err_q <= 1'b1;
                        err_code_q  <= 2'b11;
                        state_q     <= IDLE;
                    end else if (!in_valid) begin
                        idle_q <= idle_q + 8'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign frame_ok  = frame_ok_q;
    assign frame_err = frame_err_q;
    assign err_code  = err_code_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_rcv_frame_ctrl.sv
// Directed bench for rcv_frame_ctrl: a per-cycle vector table for the basic frames,
// then hand-written backpressure, timeout and mid-frame reset sequences.
module tb_rcv_frame_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_last;
    logic       out_ready;
    logic       frame_ok;
    logic       frame_err;
    logic [1:0] err_code;
    logic [7:0] frame_cnt;

    int n_vec = 0;
    int n_err = 0;

    rcv_frame_ctrl #(.MAX_LEN(16), .TIMEOUT(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready),
        .frame_ok  (frame_ok),
        .frame_err (frame_err),
        .err_code  (err_code),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      nm;
        logic       iv;
        logic [7:0] d;
        logic       ordy;
        logic       rdy;
        logic       ov;
        logic [7:0] od;
        logic       ol;
        logic       ok;
        logic       err;
        logic [1:0] code;
        logic [7:0] cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input string nm, input logic iv, input logic [7:0] d,
                                input logic ov, input logic [7:0] od, input logic ol,
                                input logic ok, input logic err, input logic [1:0] code,
                                input logic [7:0] cnt);
        vec_t v;
        v.nm = nm; v.iv = iv; v.d = d; v.ordy = 1'b1; v.rdy = 1'b1;
        v.ov = ov; v.od = od; v.ol = ol; v.ok = ok; v.err = err; v.code = code; v.cnt = cnt;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [7:0] d, input logic ordy);
        @(negedge clk);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Packed view {ov, od, ol, ok, err, code, cnt} for the reset check.
    function automatic logic [31:0] all_regs();
        return {10'd0, out_valid, out_data, out_last, frame_ok, frame_err, err_code, frame_cnt};
    endfunction

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", all_regs(), 32'd0);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        //              name       iv  d      ov  od     ol  ok  err code   cnt
        tbl.push_back(mk("gf_len",  1, 8'h03, 0, 8'h00, 0,  0,  0, 2'b00, 8'd0));
        tbl.push_back(mk("gf_p0",   1, 8'h10, 1, 8'h10, 0,  0,  0, 2'b00, 8'd0));
        tbl.push_back(mk("gf_p1",   1, 8'h20, 1, 8'h20, 0,  0,  0, 2'b00, 8'd0));
        tbl.push_back(mk("gf_p2",   1, 8'h30, 1, 8'h30, 1,  0,  0, 2'b00, 8'd0));
        tbl.push_back(mk("gf_ck",   1, 8'h63, 0, 8'h00, 0,  1,  0, 2'b00, 8'd1));
        tbl.push_back(mk("bc_len",  1, 8'h02, 0, 8'h00, 0,  0,  0, 2'b00, 8'd1));
        tbl.push_back(mk("bc_p0",   1, 8'hAA, 1, 8'hAA, 0,  0,  0, 2'b00, 8'd1));
        tbl.push_back(mk("bc_p1",   1, 8'h55, 1, 8'h55, 1,  0,  0, 2'b00, 8'd1));
        tbl.push_back(mk("bc_ck",   1, 8'h00, 0, 8'h00, 0,  0,  1, 2'b10, 8'd1));
        tbl.push_back(mk("bl_00",   1, 8'h00, 0, 8'h00, 0,  0,  1, 2'b01, 8'd1));
        tbl.push_back(mk("bl_11",   1, 8'h11, 0, 8'h00, 0,  0,  1, 2'b01, 8'd1));
        tbl.push_back(mk("bl_idle", 0, 8'h00, 0, 8'h00, 0,  0,  0, 2'b01, 8'd1));
        tbl.push_back(mk("f1_len",  1, 8'h01, 0, 8'h00, 0,  0,  0, 2'b01, 8'd1));
        tbl.push_back(mk("f1_p0",   1, 8'h7F, 1, 8'h7F, 1,  0,  0, 2'b01, 8'd1));
        tbl.push_back(mk("f1_ck",   1, 8'h80, 0, 8'h00, 0,  1,  0, 2'b01, 8'd2));

        foreach (tbl[i]) begin
            logic [31:0] got, exp;
            drive(tbl[i].iv, tbl[i].d, tbl[i].ordy);
            chk({tbl[i].nm, "_in_ready"}, {31'd0, in_ready}, {31'd0, tbl[i].rdy});
            tick();
            got = {10'd0, out_valid, tbl[i].ov ? out_data : 8'h00, tbl[i].ov ? out_last : 1'b0,
                   frame_ok, frame_err, err_code, frame_cnt};
            exp = {10'd0, tbl[i].ov, tbl[i].od, tbl[i].ol, tbl[i].ok, tbl[i].err,
                   tbl[i].code, tbl[i].cnt};
            chk(tbl[i].nm, got, exp);
        end

        // Backpressure: downstream stalls 20 cycles after the first payload byte.
        drive(1, 8'h04, 1); tick();
        drive(1, 8'h01, 1); tick();
        chk("bp_first", {23'd0, out_valid, out_data}, {23'd0, 1'b1, 8'h01});
        for (int k = 0; k < 20; k++) begin
            drive(1, 8'h02, 0);
            chk("bp_stall_in_ready", {31'd0, in_ready}, 32'd0);
            tick();
            chk("bp_stall_hold", {22'd0, out_valid, out_data, frame_err},
                {22'd0, 1'b1, 8'h01, 1'b0});
        end
        drive(1, 8'h02, 1); chk("bp_resume_in_ready", {31'd0, in_ready}, 32'd1); tick();
        chk("bp_p1", {22'd0, out_valid, out_data, out_last}, {22'd0, 1'b1, 8'h02, 1'b0});
        drive(1, 8'h03, 1); tick();
        chk("bp_p2", {22'd0, out_valid, out_data, out_last}, {22'd0, 1'b1, 8'h03, 1'b0});
        drive(1, 8'h04, 1); tick();
        chk("bp_p3", {22'd0, out_valid, out_data, out_last}, {22'd0, 1'b1, 8'h04, 1'b1});
        drive(1, 8'h0E, 1); tick();
        chk("bp_ok", {22'd0, frame_ok, frame_err, frame_cnt}, {22'd0, 1'b1, 1'b0, 8'd3});

        // Timeout: held byte must survive the abort, error lands after exactly 8 idle edges.
        drive(1, 8'h05, 0); tick();
        drive(1, 8'h01, 0); tick();
        chk("to_loaded", {23'd0, out_valid, out_data}, {23'd0, 1'b1, 8'h01});
        begin
            int hit = 0;
            for (int k = 1; k <= 20 && hit == 0; k++) begin
                drive(0, 8'h00, 0);
                tick();
                if (frame_err) hit = k;
            end
            chk("to_idle_cycles", hit, 8);
            chk("to_code", {30'd0, err_code}, {30'd0, 2'b11});
            chk("to_byte_held", {22'd0, out_valid, out_data, out_last}, {22'd0, 1'b1, 8'h01, 1'b0});
        end
        drive(0, 8'h00, 1); tick();
        chk("to_drained", {30'd0, out_valid, frame_err}, 32'd0);
        drive(1, 8'h01, 1); tick();
        drive(1, 8'h7F, 1); tick();
        chk("to_next_p0", {22'd0, out_valid, out_data, out_last}, {22'd0, 1'b1, 8'h7F, 1'b1});
        drive(1, 8'h80, 1); tick();
        chk("to_next_ok", {22'd0, frame_ok, frame_err, frame_cnt}, {22'd0, 1'b1, 1'b0, 8'd4});

        // Reset mid-frame discards silently.
        drive(1, 8'h03, 1); tick();
        drive(1, 8'h11, 1); tick();
        chk("rst_pre", {23'd0, out_valid, out_data}, {23'd0, 1'b1, 8'h11});
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b0;
        #1;
        chk("rst_async", all_regs(), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_outputs", all_regs(), 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 8'h00, 1); tick();
        chk("rst_no_err", {30'd0, frame_ok, frame_err}, 32'd0);
        drive(1, 8'h01, 1); tick();
        drive(1, 8'h05, 1); tick();
        chk("rst_p0", {22'd0, out_valid, out_data, out_last}, {22'd0, 1'b1, 8'h05, 1'b1});
        drive(1, 8'h06, 1); tick();
        chk("rst_ok", {22'd0, frame_ok, frame_err, frame_cnt}, {22'd0, 1'b1, 1'b0, 8'd1});
        drive(0, 8'h00, 1); tick();
        chk("rst_ok_pulse_end", {31'd0, frame_ok}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/rcv_frame_ctrl.md
# rcv_frame_ctrl

Receive-path sequencer between the byte-producing receive stage and the byte-consuming receive stage. It parses a length-prefixed frame from the incoming byte stream and forwards the payload bytes downstream through a one-entry output register with valid/ready handshakes. It verifies an 8-bit additive checksum, flags malformed or stalled frames, and counts good frames.

## Interface

- Clocking: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- `MAX_LEN`, default 16: largest legal payload length in bytes (1..255).
- `TIMEOUT`, default 255: number of consecutive upstream-idle cycles mid-frame before abort (1..255).
- `clk` input 1: clock; all state updates on rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `in_valid` input 1: upstream byte valid.
- `in_data` input 8: upstream byte.
- `in_ready` output 1: controller accepts byte this cycle.
- `out_valid` output 1: payload byte held in output register.
- `out_data` output 8: payload byte.
- `out_last` output 1: held byte is final payload byte of frame.
- `out_ready` input 1: downstream accepts byte.
- `frame_ok` output 1: one-cycle pulse, frame checksum good.
- `frame_err` output 1: one-cycle pulse, frame aborted.
- `err_code` output 2: valid with `frame_err`: 01 bad length, 10 checksum mismatch, 11 timeout; holds last value otherwise.
- `frame_cnt` output 8: good-frame count, wraps 255->0.

## Operation

- Frame format: byte 0 = length L, then L payload bytes, then checksum byte C. C must equal (L + sum of payload) mod 256.
- Accept means `in_valid & in_ready` at a rising edge.
- FSM states are IDLE, PAYLOAD and CHECK.
- IDLE: `in_ready`=1. On an accepted byte, if 1 <= byte <= MAX_LEN, latch L, init the 8-bit running sum to the byte, load the remaining-byte counter with L, and go to PAYLOAD. Otherwise pulse `frame_err` with code 01 and stay in IDLE; the next byte is treated as a new length byte.
- PAYLOAD: `in_ready` = !out_valid | out_ready. Each accepted byte is added to the sum (mod 256), loaded into the output register, and decrements the counter. `out_last`=1 when the counter goes 1->0. The counter reaching 0 moves the FSM to CHECK.
- CHECK: `in_ready`=1. On accept, compare the byte to the sum. If equal, pulse `frame_ok` and increment `frame_cnt`; if not, pulse `frame_err` with code 10. In both cases go to IDLE.
- Output register: set `out_valid` on payload accept. Clear it on `out_ready` when there is no simultaneous new load. A simultaneous drain and load replaces the held byte with the new one and keeps `out_valid`=1.
- The output register drains independently of FSM state; the last payload byte may still be pending while CHECK/IDLE proceed.
- Timeout: the idle counter runs only in PAYLOAD/CHECK.
  - It increments on cycles with `in_valid`=0 and clears on any accept or state entry.
  - Cycles with `in_valid`=1 but `in_ready`=0 (downstream backpressure) do not count.
  - Reaching TIMEOUT pulses `frame_err` with code 11 and moves the FSM to IDLE.
  - A byte already in the output register is still delivered; its `out_last` stays as loaded.
- Simultaneous timeout and accept in the same cycle: the accept wins and the counter clears.

## Timing

- Reset values: FSM=IDLE, `out_valid`=0, `out_data`=0, `out_last`=0, `frame_ok`=0, `frame_err`=0, `err_code`=00, `frame_cnt`=0, sum/counters=0. Reset mid-frame discards the frame silently with no error pulse.
- `in_ready` is combinational from state, `out_valid` and `out_ready`. All other outputs are registered.
- Latency: an accepted payload byte appears on `out_data` with `out_valid`=1 the next cycle.
- `frame_ok`/`frame_err` are high for exactly the one cycle after the accepting or timeout edge.
- Throughput: one byte per cycle when `out_ready` is held 1. A frame of L bytes occupies L+2 input cycles.
- No bubble is required between frames: a length byte may be accepted the cycle after the checksum byte.

## Test plan

- Good frame: bytes 03,10,20,30,63 with `out_ready`=1.
  - Expect out_data 10,20,30 on consecutive cycles, `out_last` on 30.
  - Expect `frame_ok` pulse one cycle after 63 is accepted, and `frame_cnt` 0->1.
- Bad checksum: 02,AA,55,00 -> 2 payload bytes forwarded, `frame_err` with `err_code`=10, `frame_cnt` unchanged.
- Bad length: 00, then 11 with MAX_LEN=16 -> two `frame_err` pulses with code 01, no `out_valid`, FSM stays in IDLE.
- Backpressure: frame 04,01,02,03,04,0E with `out_ready` low for 20 cycles after the first payload byte.
  - Expect `in_ready`=0 while stalled, no timeout, all bytes delivered in order, then `frame_ok`.
- Timeout: TIMEOUT=8; send 05,01 then hold `in_valid`=0.
  - Expect `frame_err` with code 11 after exactly 8 idle cycles and byte 01 still delivered.
  - Follow with frame 01,7F,80 -> `frame_ok`.
- Reset mid-frame: send 03,11; assert `rst_n`=0 for 2 cycles -> all outputs return to reset values. Then 01,05,06 -> `frame_ok`, `frame_cnt`=1.
